// File: rtl/obstacle_sched_pkg.sv
// obstacle_sched_pkg
// Shared types and constants for the obstacle scheduler: game state enum,
// LFSR feedback taps, default screen bounds and a small abs helper used by
// the collision compare.
package obstacle_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } sched_state_t;

    localparam int COORD_W = 10;

    // x^10 + x^7 + 1 : feedback is the XOR of bits 9 and 6
    localparam logic [9:0] LFSR_TAPS = 10'b10_0100_0000;

    localparam int DEF_X_MAX    = 639;
    localparam int DEF_Y_MAX    = 479;
    localparam int DEF_OBS_SIZE = 16;

    // Magnitude of an 11-bit signed difference of two 10-bit coordinates.
    // The most negative value reachable is -1023, so the result never wraps.
    function automatic logic [10:0] abs11(input logic signed [10:0] d);
        logic [10:0] r;
        r = d[10] ? (~d + 11'd1) : d;
        return r;
    endfunction

endpackage

// File: rtl/lfsr10.sv
// lfsr10
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1) that shifts left and feeds the tap
// parity into bit 0. Supplies the spawn row offset.
// Ports:
//   frame_clk  in   clock, one step per rising edge when enabled
//   Reset      in   synchronous active-high, loads SEED
//   en         in   advance enable
//   value      out  current 10-bit register contents
module lfsr10
    import obstacle_sched_pkg::*;
#(
    parameter logic [9:0] SEED = 10'h2A5
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       en,
    output logic [9:0] value
);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            value <= SEED;
        end else if (en) begin
            value <= {value[8:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
// Frame-rate owner of a fixed pool of obstacle slots. Spawns at the right
// edge every SPAWN_INTERVAL frames, scrolls live obstacles left by `speed`,
// retires them at the left edge and stops the game on contact with the
// player box.
// Ports:
//   frame_clk    in   frame clock
//   Reset        in   synchronous active-high
//   start        in   level; starts from IDLE, restarts from HIT
//   speed        in   [3:0] leftward pixels per frame
//   player_x/y   in   [9:0] player centre
//   player_size  in   [9:0] player half-size
//   obs_x/obs_y  out  packed slot centres, slot i at [10i+9:10i]
//   obs_active   out  per-slot live flag
//   game_over    out  high while in HIT
//   score        out  RUN frames survived, saturating
module obstacle_scheduler
    import obstacle_sched_pkg::*;
#(
    parameter int         NUM_SLOTS      = 4,
    parameter int         SPAWN_INTERVAL = 60,
    parameter int         OBS_SIZE       = DEF_OBS_SIZE,
    parameter int         X_MAX          = DEF_X_MAX,
    parameter int         Y_MAX          = DEF_Y_MAX,
    parameter logic [9:0] LFSR_SEED      = 10'h2A5
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic                           start,
    input  logic [3:0]                     speed,
    input  logic [COORD_W-1:0]             player_x,
    input  logic [COORD_W-1:0]             player_y,
    input  logic [COORD_W-1:0]             player_size,
    output logic [COORD_W*NUM_SLOTS-1:0]   obs_x,
    output logic [COORD_W*NUM_SLOTS-1:0]   obs_y,
    output logic [NUM_SLOTS-1:0]           obs_active,
    output logic                           game_over,
    output logic [15:0]                    score
);

    localparam int                 CNT_W    = $clog2(SPAWN_INTERVAL);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [9:0]         SPAWN_X  = 10'(X_MAX - OBS_SIZE);
    localparam logic [9:0]         OFF_MAX  = 10'(Y_MAX - 2 * OBS_SIZE);

    sched_state_t state, state_next;

    logic [NUM_SLOTS-1:0][COORD_W-1:0] xs, ys, xs_nxt, ys_nxt;
    logic [NUM_SLOTS-1:0]              active, active_nxt;
    logic [NUM_SLOTS-1:0]              hit_vec, free, spawn_sel;
    logic [CNT_W-1:0]                  spawn_cnt;
    logic [15:0]                       score_q;
    logic [9:0]                        lfsr, off, spawn_y;
    logic [11:0]                       reach;
    logic [10:0]                       despawn_lim;
    logic                              any_hit, advance, clear_all, spawn_now;

    lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .en        (1'b1),
        .value     (lfsr)
    );

    // Collision and despawn thresholds are widened so the sums cannot wrap.
    assign reach       = 12'(OBS_SIZE) + {2'b00, player_size};
    assign despawn_lim = 11'(OBS_SIZE) + {7'b0, speed};

    // Row offset from the low 9 LFSR bits, folded back by 256 when it would
    // push the obstacle past the bottom edge.
    always_comb begin
        off = lfsr & 10'h1FF;
        if (off > OFF_MAX) off = off - 10'd256;
        spawn_y = 10'(OBS_SIZE) + off;
    end

    // Lowest-index free slot, taken from the mask at the start of the frame
    // so a slot retired this frame is never refilled in the same frame.
    assign free      = ~active;
    assign spawn_sel = free & (~free + NUM_SLOTS'(1));

    assign any_hit   = |hit_vec;
    assign advance   = (state == RUN) && !any_hit;
    assign clear_all = (state == IDLE) || ((state == HIT) && start);
    assign spawn_now = (spawn_cnt == CNT_LAST);

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic [10:0]        adx, ady;
        logic               gone;
        logic [COORD_W-1:0] x_n, y_n;
        logic               a_n;

        assign adx = abs11($signed({1'b0, xs[i]}) - $signed({1'b0, player_x}));
        assign ady = abs11($signed({1'b0, ys[i]}) - $signed({1'b0, player_y}));

        assign hit_vec[i] = active[i] && ({1'b0, adx} < reach) && ({1'b0, ady} < reach);
        assign gone       = {1'b0, xs[i]} < despawn_lim;

        always_comb begin
            x_n = xs[i];
            y_n = ys[i];
            a_n = active[i];
            if (clear_all) begin
                x_n = '0;
                y_n = '0;
                a_n = 1'b0;
            end else if (advance) begin
                if (active[i]) begin
                    // A retired slot keeps its last position; only the flag drops.
                    if (gone) a_n = 1'b0;
                    else      x_n = xs[i] - {6'b0, speed};
                end else if (spawn_now && spawn_sel[i]) begin
                    x_n = SPAWN_X;
                    y_n = spawn_y;
                    a_n = 1'b1;
                end
            end
        end

        assign xs_nxt[i]     = x_n;
        assign ys_nxt[i]     = y_n;
        assign active_nxt[i] = a_n;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)   state_next = RUN;
            RUN:     if (any_hit) state_next = HIT;
            HIT:     if (start)   state_next = RUN;
            default:              state_next = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            xs        <= '0;
            ys        <= '0;
            active    <= '0;
            spawn_cnt <= '0;
            score_q   <= '0;
            game_over <= 1'b0;
        end else begin
            xs        <= xs_nxt;
            ys        <= ys_nxt;
            active    <= active_nxt;
            game_over <= (state_next == HIT);
            if (clear_all) begin
                spawn_cnt <= '0;
                score_q   <= '0;
            end else if (advance) begin
                spawn_cnt <= spawn_now ? '0 : spawn_cnt + CNT_W'(1);
                if (score_q != 16'hFFFF) score_q <= score_q + 16'd1;
            end
        end
    end

    assign obs_x      = xs;
    assign obs_y      = ys;
    assign obs_active = active;
    assign score      = score_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler
// Scoreboard bench: each frame the driver steps a behavioural model of the
// game and queues the expected outputs; a monitor compares after every edge.
// Directed spot checks ride the same monitor through a second queue.
module tb_obstacle_scheduler;

    localparam int NS = 4, SI = 60, OS = 16, XM = 639, YM = 479;

    logic                 frame_clk = 1'b0;
    logic                 Reset = 1'b1, start = 1'b0;
    logic [3:0]           speed = '0;
    logic [9:0]           player_x = '0, player_y = '0, player_size = '0;
    logic [10*NS-1:0]     obs_x, obs_y;
    logic [NS-1:0]        obs_active;
    logic                 game_over;
    logic [15:0]          score;

    always #5 frame_clk = ~frame_clk;

    obstacle_scheduler #(
        .NUM_SLOTS(NS), .SPAWN_INTERVAL(SI), .OBS_SIZE(OS),
        .X_MAX(XM), .Y_MAX(YM), .LFSR_SEED(10'h2A5)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .start(start), .speed(speed),
        .player_x(player_x), .player_y(player_y), .player_size(player_size),
        .obs_x(obs_x), .obs_y(obs_y), .obs_active(obs_active),
        .game_over(game_over), .score(score)
    );

    typedef struct {
        logic [10*NS-1:0] x;
        logic [10*NS-1:0] y;
        logic [NS-1:0]    a;
        logic             go;
        logic [15:0]      sc;
    } exp_t;

    typedef struct {
        int field;
        int lo;
        int hi;
    } dchk_t;

    exp_t  q[$];
    dchk_t dq[$];
    string dn[$];
    int    n_chk = 0, n_pass = 0;
    bit    done = 0;

    // ---------------- reference model (0 idle, 1 run, 2 hit) ----------------
    int m_state, m_score, m_cnt, m_lfsr;
    int mx[NS], my[NS];
    bit ma[NS];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void clear_slots();
        for (int i = 0; i < NS; i++) begin
            mx[i] = 0; my[i] = 0; ma[i] = 0;
        end
    endfunction

    function automatic void model_step(input bit rst, input bit st, input int spd,
                                       input int px, input int py, input int psz);
        int  fb, off;
        bit  hit, placed;
        bit  was[NS];
        if (rst) begin
            m_state = 0; m_score = 0; m_cnt = 0; m_lfsr = 'h2A5;
            clear_slots();
            return;
        end
        fb = ((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1;
        case (m_state)
            0: if (st) m_state = 1;
            1: begin
                hit = 0;
                for (int i = 0; i < NS; i++)
                    if (ma[i] && iabs(mx[i] - px) < OS + psz && iabs(my[i] - py) < OS + psz)
                        hit = 1;
                if (hit) begin
                    m_state = 2;
                end else begin
                    for (int i = 0; i < NS; i++) was[i] = ma[i];
                    for (int i = 0; i < NS; i++)
                        if (ma[i]) begin
                            if (mx[i] < OS + spd) ma[i] = 0;
                            else                  mx[i] = mx[i] - spd;
                        end
                    if (m_cnt == SI - 1) begin
                        m_cnt = 0;
                        placed = 0;
                        for (int i = 0; i < NS; i++)
                            if (!was[i] && !placed) begin
                                off = m_lfsr % 512;
                                if (off > YM - 2 * OS) off = off - 256;
                                mx[i] = XM - OS; my[i] = OS + off; ma[i] = 1;
                                placed = 1;
                            end
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                    if (m_score < 65535) m_score = m_score + 1;
                end
            end
            default: if (st) begin
                m_state = 1; m_score = 0; m_cnt = 0;
                clear_slots();
            end
        endcase
        m_lfsr = ((m_lfsr << 1) & 'h3FF) | fb;
    endfunction

    // ---------------- driver ----------------
    task automatic frame(input bit rst, input bit st, input int spd,
                         input int px, input int py, input int psz);
        exp_t e;
        @(negedge frame_clk);
        Reset = rst; start = st; speed = 4'(spd);
        player_x = 10'(px); player_y = 10'(py); player_size = 10'(psz);
        model_step(rst, st, spd, px, py, psz);
        for (int i = 0; i < NS; i++) begin
            e.x[i*10 +: 10] = 10'(mx[i]);
            e.y[i*10 +: 10] = 10'(my[i]);
            e.a[i]          = ma[i];
        end
        e.go = (m_state == 2);
        e.sc = 16'(m_score);
        q.push_back(e);
        @(posedge frame_clk);
        #2;
    endtask

    // Field codes: 0 active mask, 1 slot0 x, 2 slot0 y, 3 game_over, 4 score, 5 slot0 active.
    // Applies to the outputs after the next frame() call.
    task automatic dexp(input string nm, input int f, input int lo, input int hi);
        dchk_t d;
        d.field = f; d.lo = lo; d.hi = hi;
        dq.push_back(d);
        dn.push_back(nm);
    endtask

    // ---------------- monitor ----------------
    always @(posedge frame_clk) begin : mon
        exp_t  e;
        dchk_t d;
        string nm;
        int    act;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (obs_x === e.x && obs_y === e.y && obs_active === e.a &&
                game_over === e.go && score === e.sc)
                n_pass++;
            else
                $display("FAIL scoreboard t=%0t: got a=%h x=%h y=%h go=%b score=%0d, want a=%h x=%h y=%h go=%b score=%0d",
                         $time, obs_active, obs_x, obs_y, game_over, score,
                         e.a, e.x, e.y, e.go, e.sc);
            while (dq.size() > 0) begin
                d  = dq.pop_front();
                nm = dn.pop_front();
                case (d.field)
                    0:       act = int'(obs_active);
                    1:       act = int'(obs_x[9:0]);
                    2:       act = int'(obs_y[9:0]);
                    3:       act = int'(game_over);
                    4:       act = int'(score);
                    default: act = int'(obs_active[0]);
                endcase
                n_chk++;
                if (act >= d.lo && act <= d.hi) n_pass++;
                else $display("FAIL %s: got %0d, want %0d..%0d", nm, act, d.lo, d.hi);
            end
        end
        if (done) begin
            n_chk++;
            if (q.size() == 0 && dq.size() == 0) n_pass++;
            else $display("FAIL drain: %0d expectations left unchecked", q.size() + dq.size());
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int y0, spd, px, py, psz, guard;
        bit r, s;

        repeat (3) frame(1, 0, 0, 0, 0, 0);
        dexp("reset_active", 0, 0, 0);
        dexp("reset_score", 4, 0, 0);
        dexp("reset_game_over", 3, 0, 0);
        frame(1, 0, 0, 0, 0, 0);

        // First spawn 60 frames after entering RUN, then moves by speed.
        frame(0, 1, 2, 0, 0, 0);
        repeat (59) frame(0, 0, 2, 0, 0, 0);
        dexp("first_spawn_active", 5, 1, 1);
        dexp("first_spawn_x", 1, 623, 623);
        dexp("first_spawn_y", 2, 16, 463);
        frame(0, 0, 2, 0, 0, 0);
        dexp("first_move_x", 1, 621, 621);
        frame(0, 0, 2, 0, 0, 0);

        // Frozen motion: pool fills, fifth attempt dropped.
        repeat (239) frame(0, 0, 0, 0, 0, 0);
        dexp("pool_full", 0, 15, 15);
        dexp("frozen_x", 1, 621, 621);
        frame(0, 0, 0, 0, 0, 0);

        // Left-edge boundary at speed 5: 21 survives to 16, then 16 retires.
        repeat (119) frame(0, 0, 5, 0, 0, 0);
        dexp("edge_x21", 1, 21, 21);
        frame(0, 0, 5, 0, 0, 0);
        dexp("edge_x16", 1, 16, 16);
        dexp("edge_x16_live", 5, 1, 1);
        frame(0, 0, 5, 0, 0, 0);
        dexp("edge_all_retired", 0, 0, 0);
        frame(0, 0, 5, 0, 0, 0);

        // x=20 at speed 5 retires.
        guard = 0;
        while (!ma[0] && guard < 2 * SI) begin
            frame(0, 0, 0, 0, 0, 0);
            guard++;
        end
        frame(0, 0, 3, 0, 0, 0);
        repeat (119) frame(0, 0, 5, 0, 0, 0);
        dexp("edge_x20", 1, 20, 20);
        frame(0, 0, 5, 0, 0, 0);
        dexp("edge_x20_retired", 5, 0, 0);
        frame(0, 0, 5, 0, 0, 0);

        // Collision with a freshly spawned obstacle.
        frame(1, 0, 0, 0, 0, 0);
        frame(0, 1, 0, 0, 0, 0);
        repeat (60) frame(0, 0, 0, 0, 0, 0);
        y0 = my[0];
        dexp("hit_game_over", 3, 1, 1);
        dexp("hit_x_held", 1, 623, 623);
        dexp("hit_score_held", 4, 60, 60);
        frame(0, 0, 0, 621, y0, 8);
        repeat (4) frame(0, 0, 3, 621, y0, 8);
        dexp("hit_frozen_x", 1, 623, 623);
        dexp("hit_frozen_score", 4, 60, 60);
        frame(0, 0, 3, 621, y0, 8);

        // Restart from HIT.
        dexp("restart_active", 0, 0, 0);
        dexp("restart_score", 4, 0, 0);
        dexp("restart_game_over", 3, 0, 0);
        frame(0, 1, 2, 0, 0, 0);
        repeat (58) frame(0, 0, 2, 0, 0, 0);
        dexp("restart_no_early_spawn", 5, 0, 0);
        frame(0, 0, 2, 0, 0, 0);
        dexp("restart_spawn", 5, 1, 1);
        frame(0, 0, 2, 0, 0, 0);

        // Reset in the middle of a game with three live slots.
        repeat (119) frame(0, 0, 0, 0, 0, 0);
        dexp("three_live", 0, 7, 7);
        frame(0, 0, 0, 0, 0, 0);
        dexp("midreset_active", 0, 0, 0);
        dexp("midreset_x", 1, 0, 0);
        dexp("midreset_y", 2, 0, 0);
        dexp("midreset_score", 4, 0, 0);
        dexp("midreset_game_over", 3, 0, 0);
        frame(1, 0, 0, 0, 0, 0);
        frame(0, 1, 4, 0, 0, 0);
        repeat (70) frame(0, 0, 4, 0, 0, 0);

        // Randomised play.
        spd = 3; px = 320; py = 240; psz = 10;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 999) == 0);
            s = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) spd = int'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) begin
                px  = int'($urandom_range(0, 639));
                py  = int'($urandom_range(0, 479));
                psz = int'($urandom_range(0, 40));
            end
            frame(r, s, spd, px, py, psz);
        end

        done = 1;
    end

endmodule
